// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the fetch stage.
//   XLEN / ILEN       : address and instruction widths
//   RESET_PC_DEFAULT  : default PC of the first fetch after reset
//   fetch_state_t     : fetch FSM states
package cpu_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // FETCH : may issue a request
  // WAIT  : one request outstanding, its data is wanted
  // DROP  : one request outstanding, its data is stale and is discarded
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DROP  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO that buffers fetched {pc, instr} pairs.
//   clk, rst     : clock, asynchronous active-low reset
//   i_push/i_data: write an entry
//   i_pop        : remove the head entry
//   i_flush      : empty the FIFO (wins over push and pop)
//   o_data       : head entry, stable while not popped
//   o_empty      : no entries held
//   o_count      : number of entries held (0..DEPTH)
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  input  logic                   i_flush,
  output logic [WIDTH-1:0]       o_data,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  // DEPTH is a power of two, so "full" is just the count MSB pattern.
  localparam logic [CW-1:0] CNT_FULL = {1'b1, {AW{1'b0}}};

  logic [DEPTH-1:0][WIDTH-1:0] r_mem;
  logic [AW-1:0]               r_wr;
  logic [AW-1:0]               r_rd;
  logic [CW-1:0]               r_cnt;

  logic w_full;
  logic w_do_push;
  logic w_do_pop;

  assign w_full    = (r_cnt == CNT_FULL);
  assign o_empty   = (r_cnt == '0);
  assign w_do_pop  = i_pop && !o_empty;
  // A push into a full FIFO only makes room if a pop happens in the same cycle.
  assign w_do_push = i_push && (!w_full || w_do_pop);

  assign o_data  = r_mem[r_rd];
  assign o_count = r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else if (i_flush) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + AW'(1);
      if (w_do_pop)  r_rd <= r_rd + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Storage needs no reset; the pointers decide what is visible.
  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) r_mem[r_wr] <= i_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage.
// Owns the PC, issues one word read at a time to instruction memory
// (req/gnt/rvalid), buffers returned {pc, instr} pairs and hands them to
// decode with valid/ready. A redirect from execute flushes the buffer and
// turns any outstanding read into a dropped one.
//   clk, rst                    : clock, asynchronous active-low reset
//   imem_req/imem_addr/imem_gnt : request channel (req&gnt = accepted)
//   imem_rvalid/imem_rdata      : response channel
//   redirect_valid/redirect_pc  : new PC from execute, low two bits ignored
//   if_valid/if_ready           : decode handshake
//   if_instr/if_pc              : head instruction and its PC
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [ILEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [ILEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t    r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_req_pc;   // PC of the outstanding request
  logic            r_en;       // low during reset and for the first cycle after

  logic                 w_issue;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_empty;
  logic [CW-1:0]        w_count;
  logic [XLEN+ILEN-1:0] w_head;
  logic                 w_unused_rpc;

  // Space is reserved at issue time: count cannot grow while a read is
  // outstanding, so the response always has a slot.
  assign imem_req  = r_en && (r_state == FETCH) && (w_count < CW'(FIFO_DEPTH));
  assign imem_addr = r_pc;
  assign w_issue   = imem_req && imem_gnt;

  assign w_push   = (r_state == WAIT) && imem_rvalid && !redirect_valid;
  assign if_valid = !w_empty && !redirect_valid;
  assign w_pop    = if_valid && if_ready;

  assign if_pc    = w_head[XLEN+ILEN-1:ILEN];
  assign if_instr = w_head[ILEN-1:0];

  assign w_unused_rpc = ^redirect_pc[1:0];

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (XLEN + ILEN)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  ({r_req_pc, imem_rdata}),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .o_data  (w_head),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= FETCH;
      r_pc     <= RESET_PC;
      r_req_pc <= '0;
      r_en     <= 1'b0;
    end else begin
      r_en <= 1'b1;
      if (redirect_valid) begin
        // Redirect beats everything; whatever is in flight becomes stale.
        r_pc <= {redirect_pc[XLEN-1:2], 2'b00};
        case (r_state)
          FETCH:   r_state <= w_issue     ? DROP  : FETCH;
          WAIT:    r_state <= imem_rvalid ? FETCH : DROP;
          DROP:    r_state <= imem_rvalid ? FETCH : DROP;
          default: r_state <= FETCH;
        endcase
      end else begin
        case (r_state)
          FETCH: if (w_issue) begin
            r_req_pc <= r_pc;
            r_pc     <= r_pc + 32'd4;
            r_state  <= WAIT;
          end
          WAIT:    if (imem_rvalid) r_state <= FETCH;
          DROP:    if (imem_rvalid) r_state <= FETCH;
          default: r_state <= FETCH;
        endcase
      end
    end
  end

  // A response with nothing outstanding is a memory protocol violation.
  a_no_rvalid_in_fetch: assert property (
    @(posedge clk) disable iff (!rst) !(imem_rvalid && (r_state == FETCH))
  );

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  int n_checks = 0;
  int n_fail   = 0;

  // memory model controls
  logic        mem_stall    = 1'b0;
  logic        mem_flush    = 1'b0;
  logic        mem_force_rv = 1'b0;
  logic        pend         = 1'b0;
  logic [31:0] pend_addr    = 32'h0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  // 1-cycle latency memory, driven on the falling edge. A request seen here
  // is accepted on the next rising edge and answered on the one after.
  always @(negedge clk) begin
    imem_rvalid = 1'b0;
    if (mem_flush) pend = 1'b0;
    if (mem_force_rv) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hBAD0_BAD0;
    end else if (pend && !mem_stall) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(pend_addr);
      pend        = 1'b0;
    end
    if (imem_req && imem_gnt) begin
      pend      = 1'b1;
      pend_addr = imem_addr;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #1;
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", imem_req); end
    n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", if_valid); end
    @(posedge clk);
    #1 rst = 1'b1;
    tick();
    n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL first_req: got %b want 1", imem_req); end
    n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL first_addr: got %h want 00000000", imem_addr); end
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    int n_out;
    exp_pc = 32'h0;
    n_out  = 0;
    if_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (if_valid) begin
        n_checks++; if (if_pc !== exp_pc) begin n_fail++; $display("FAIL stream_pc: got %h want %h", if_pc, exp_pc); end
        n_checks++; if (if_instr !== mem_word(exp_pc)) begin n_fail++; $display("FAIL stream_instr: got %h want %h", if_instr, mem_word(exp_pc)); end
        exp_pc = exp_pc + 32'd4;
        n_out++;
      end
    end
    n_checks++; if (n_out != 6) begin n_fail++; $display("FAIL stream_rate: got %0d instrs want 6", n_out); end
  endtask

  task automatic test_backpressure();
    if_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'd20) begin n_fail++; $display("FAIL bp_hold: got v=%b pc=%h want v=1 pc=00000014", if_valid, if_pc); end
    end
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL bp_full_req: got %b want 0", imem_req); end
    n_checks++; if (if_instr !== mem_word(32'd20)) begin n_fail++; $display("FAIL bp_instr: got %h want %h", if_instr, mem_word(32'd20)); end
    if_ready = 1'b1;
    tick();
    n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'd24) begin n_fail++; $display("FAIL bp_second: got v=%b pc=%h want v=1 pc=00000018", if_valid, if_pc); end
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'd28) begin n_fail++; $display("FAIL bp_resume: got req=%b addr=%h want req=1 addr=0000001c", imem_req, imem_addr); end
    tick();
    n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained: got %b want 0", if_valid); end
    for (int i = 0; i < 6 && !if_valid; i++) tick();
    n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'd28) begin n_fail++; $display("FAIL bp_next: got v=%b pc=%h want v=1 pc=0000001c", if_valid, if_pc); end
  endtask

  task automatic test_redirect_wait();
    mem_stall = 1'b1;
    tick();
    n_checks++; if (imem_req !== 1'b0 || if_valid !== 1'b0) begin n_fail++; $display("FAIL rw_wait: got req=%b v=%b want 0 0", imem_req, if_valid); end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    tick();
    redirect_valid = 1'b0;
    mem_stall      = 1'b0;
    #1;
    n_checks++; if (imem_req !== 1'b0 || if_valid !== 1'b0) begin n_fail++; $display("FAIL rw_drop: got req=%b v=%b want 0 0", imem_req, if_valid); end
    tick();
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin n_fail++; $display("FAIL rw_addr: got req=%b addr=%h want req=1 addr=00000100", imem_req, imem_addr); end
    n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rw_stale: got %b want 0", if_valid); end
    for (int i = 0; i < 6 && !if_valid; i++) tick();
    n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h100) begin n_fail++; $display("FAIL rw_first: got v=%b pc=%h want v=1 pc=00000100", if_valid, if_pc); end
    n_checks++; if (if_instr !== mem_word(32'h100)) begin n_fail++; $display("FAIL rw_instr: got %h want %h", if_instr, mem_word(32'h100)); end
  endtask

  task automatic test_redirect_gnt();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0203;
    #1;
    n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rg_mask: got %b want 0", if_valid); end
    n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL rg_req: got %b want 1", imem_req); end
    tick();
    redirect_valid = 1'b0;
    #1;
    n_checks++; if (imem_req !== 1'b0 || if_valid !== 1'b0) begin n_fail++; $display("FAIL rg_drop: got req=%b v=%b want 0 0", imem_req, if_valid); end
    tick();
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin n_fail++; $display("FAIL rg_addr: got req=%b addr=%h want req=1 addr=00000200", imem_req, imem_addr); end
    n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rg_stale: got %b want 0", if_valid); end
    for (int i = 0; i < 6 && !if_valid; i++) tick();
    n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h200) begin n_fail++; $display("FAIL rg_first: got v=%b pc=%h want v=1 pc=00000200", if_valid, if_pc); end
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    tick();
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_top: got req=%b addr=%h want req=1 addr=fffffffc", imem_req, imem_addr); end
    tick();
    for (int i = 0; i < 6 && !if_valid; i++) tick();
    n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_pc: got v=%b pc=%h want v=1 pc=fffffffc", if_valid, if_pc); end
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_next: got req=%b addr=%h want req=1 addr=00000000", imem_req, imem_addr); end
  endtask

  task automatic test_reset_in_wait();
    tick();
    tick();
    n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || imem_addr !== 32'h4) begin n_fail++; $display("FAIL rst_pre: got v=%b pc=%h addr=%h want 1 00000000 00000004", if_valid, if_pc, imem_addr); end
    if_ready  = 1'b0;
    mem_stall = 1'b1;
    tick();
    n_checks++; if (imem_req !== 1'b0 || if_valid !== 1'b1) begin n_fail++; $display("FAIL rst_wait: got req=%b v=%b want 0 1", imem_req, if_valid); end
    rst          = 1'b0;
    mem_force_rv = 1'b1;
    mem_flush    = 1'b1;
    #1;
    n_checks++; if (if_valid !== 1'b0 || imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_async: got v=%b req=%b want 0 0", if_valid, imem_req); end
    tick();
    rst          = 1'b1;
    mem_force_rv = 1'b0;
    mem_flush    = 1'b0;
    mem_stall    = 1'b0;
    if_ready     = 1'b1;
    tick();
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_restart: got req=%b addr=%h want req=1 addr=00000000", imem_req, imem_addr); end
    n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rst_empty: got %b want 0", if_valid); end
    for (int i = 0; i < 6 && !if_valid; i++) tick();
    n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== mem_word(32'h0)) begin n_fail++; $display("FAIL rst_first: got v=%b pc=%h instr=%h want 1 00000000 %h", if_valid, if_pc, if_instr, mem_word(32'h0)); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_wait();
    test_redirect_gnt();
    test_wrap();
    test_reset_in_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
